// File: rtl/uart_move_tx.sv
// Serializes a 3-byte move packet (header 0xA5, {msg_type,row,col}, checksum)
// as back-to-back 8N1 UART frames; all outputs are registered.
module uart_move_tx #(
    parameter int CLK_FREQ = 40000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [1:0] msg_type,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HEADER = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_d;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
    logic [1:0]       type_q;
    logic [2:0]       row_q, col_q;
    logic             tx_d, busy_d, done_d;
    logic             accept, bit_end;

    assign accept  = (state == IDLE) && send;
    assign bit_end = (baud_cnt == CNT_LAST);

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values; the reset lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            type_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            byte_idx <= byte_idx_d;
            bit_idx  <= bit_idx_d;
            baud_cnt <= baud_cnt_d;
            tx       <= tx_d;
            busy     <= busy_d;
            done     <= done_d;
            if (accept) begin
                type_q <= msg_type;
                row_q  <= row;
                col_q  <= col;
            end
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state;
        byte_idx_d = byte_idx;
        bit_idx_d  = bit_idx;
        baud_cnt_d = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
            IDLE: begin
                if (send) begin
                    state_d    = START;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) state_d = STOP;
                    else                 bit_idx_d = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_idx == 2'd2) begin
                        state_d    = IDLE;
                        byte_idx_d = '0;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        logic [7:0] payload;
        logic [7:0] cur_byte;
        payload = {type_q, row_q, col_q};
        case (byte_idx_d)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = payload;
            default: cur_byte = HEADER ^ payload;
        endcase
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state == STOP) && (byte_idx == 2'd2) && bit_end;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_move_tx.sv
// Bench for uart_move_tx: a cycle model of the expected line waveform checked
// every cycle, plus literal decoded-byte and timing expectations per scenario.
module tb_uart_move_tx;

    localparam int CPB      = 4;
    localparam int PKT_CYC  = 30 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [1:0] msg_type = '0;
    logic [2:0] row = '0;
    logic [2:0] col = '0;
    logic       busy, done, tx;

    int n_tests = 0;
    int n_fail  = 0;

    uart_move_tx #(.CLK_FREQ(40), .BAUD(10)) dut (
        .clk(clk), .rst(rst), .send(send), .msg_type(msg_type),
        .row(row), .col(col), .busy(busy), .done(done), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the packet (-1 when idle) and the packet bytes.
    int         m_pos = -1;
    logic       m_done = 1'b0;
    logic [7:0] m_bytes [3];

    always @(posedge clk) begin
        if (rst) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == PKT_CYC) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                end
            end else if (send) begin
                m_bytes[0] = 8'hA5;
                m_bytes[1] = {msg_type, row, col};
                m_bytes[2] = 8'hA5 ^ m_bytes[1];
                m_pos = 0;
            end
        end
    end

    function automatic logic model_tx(input int pos);
        int bitn, k;
        logic [7:0] b;
        if (pos < 0) return 1'b1;
        bitn = pos / CPB;
        k    = bitn % 10;
        b    = m_bytes[bitn / 10];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(negedge clk) begin
        check("tx", 32'(tx), 32'(model_tx(m_pos)));
        check("busy", 32'(busy), 32'(m_pos >= 0));
        check("done", 32'(done), 32'(m_done));
    end

    // Captured samples, one per cycle, taken on the falling edge.
    logic txq[$];
    logic bq[$];
    logic dq[$];

    task automatic cap_clear();
        txq.delete();
        bq.delete();
        dq.delete();
    endtask

    task automatic step_cap();
        @(negedge clk);
        txq.push_back(tx);
        bq.push_back(busy);
        dq.push_back(done);
    endtask

    function automatic logic [7:0] decode(input int base, input int b);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = txq[base + (b * 10 + 1 + k) * CPB + CPB / 2];
        return v;
    endfunction

    function automatic int count_q(input int which, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (which == 0 && bq[i]) c++;
            if (which == 1 && dq[i]) c++;
        end
        return c;
    endfunction

    function automatic int first_done();
        for (int i = 0; i < dq.size(); i++) if (dq[i]) return i;
        return -1;
    endfunction

    task automatic start_send(input logic [1:0] t, input logic [2:0] r, input logic [2:0] c);
        msg_type = t;
        row      = r;
        col      = c;
        send     = 1'b1;
    endtask

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_tx", 32'(tx), 32'd1);
        check("release_done", 32'(done), 32'd0);

        // Single packet 01/3/5.
        cap_clear();
        start_send(2'b01, 3'd3, 3'd5);
        for (int i = 0; i < 130; i++) begin
            step_cap();
            send = 1'b0;
        end
        check("p1_byte0", 32'(decode(0, 0)), 32'hA5);
        check("p1_byte1", 32'(decode(0, 1)), 32'h5D);
        check("p1_byte2", 32'(decode(0, 2)), 32'hF8);
        check("p1_busy_cycles", 32'(count_q(0, 0, 130)), 32'd120);
        check("p1_done_index", 32'(first_done()), 32'd120);
        check("p1_done_count", 32'(count_q(1, 0, 130)), 32'd1);

        // Re-pulse at cycle 50 with other fields must be ignored.
        cap_clear();
        start_send(2'b01, 3'd3, 3'd5);
        for (int i = 0; i < 130; i++) begin
            step_cap();
            send = 1'b0;
            if (i == 49) start_send(2'b10, 3'd1, 3'd6);
        end
        check("p2_byte0", 32'(decode(0, 0)), 32'hA5);
        check("p2_byte1", 32'(decode(0, 1)), 32'h5D);
        check("p2_byte2", 32'(decode(0, 2)), 32'hF8);
        check("p2_done_count", 32'(count_q(1, 0, 130)), 32'd1);

        // send held high: consecutive packets, second accepted in the done cycle.
        cap_clear();
        start_send(2'b11, 3'd7, 3'd7);
        for (int i = 0; i < 250; i++) step_cap();
        send = 1'b0;
        for (int i = 0; i < 130; i++) step_cap();
        check("p3_gap_idle", 32'(bq[120]), 32'd0);
        check("p3_second_start", 32'(bq[121]), 32'd1);
        check("p3_second_start_bit", 32'(txq[121]), 32'd0);
        check("p3a_byte1", 32'(decode(0, 1)), 32'hFF);
        check("p3a_byte2", 32'(decode(0, 2)), 32'h5A);
        check("p3b_byte0", 32'(decode(121, 0)), 32'hA5);
        check("p3b_byte1", 32'(decode(121, 1)), 32'hFF);
        check("p3b_byte2", 32'(decode(121, 2)), 32'h5A);
        check("p3_done_count", 32'(count_q(1, 0, 250)), 32'd2);

        // Reset at cycle 40 of a packet aborts it without a done pulse.
        cap_clear();
        start_send(2'b10, 3'd2, 3'd2);
        for (int i = 0; i < 40; i++) begin
            step_cap();
            send = 1'b0;
        end
        rst = 1'b1;
        send = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        send = 1'b0;
        rst  = 1'b0;
        cap_clear();
        for (int i = 0; i < 10; i++) step_cap();
        check("abort_no_done", 32'(count_q(1, 0, 10)), 32'd0);
        check("abort_stays_idle", 32'(count_q(0, 0, 10)), 32'd0);

        cap_clear();
        start_send(2'b00, 3'd0, 3'd0);
        for (int i = 0; i < 125; i++) begin
            step_cap();
            send = 1'b0;
        end
        check("p4_byte0", 32'(decode(0, 0)), 32'hA5);
        check("p4_byte1", 32'(decode(0, 1)), 32'h00);
        check("p4_byte2", 32'(decode(0, 2)), 32'hA5);
        check("p4_done_index", 32'(first_done()), 32'd120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_move_tx.md
UART_MOVE_TX -- requirements
Module: uart_move_tx

Interface
REQ-001 Parameter CLK_FREQ, default 40000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate; CLKS_PER_BIT SHALL be CLK_FREQ/BAUD (integer division; 4166 at defaults).
REQ-003 clk  input  1  system clock (40 MHz domain); one clock only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 send  input  1  request to transmit one move packet; sampled each rising edge.
REQ-006 msg_type  input  2  packet type (00 name char, 01 shot, 10 hit/miss reply, 11 control).
REQ-007 row  input  3  board row 0..7.
REQ-008 col  input  3  board column 0..7.
REQ-009 busy  output  1  high while a packet is being serialized.
REQ-010 done  output  1  one-cycle pulse on packet completion.
REQ-011 tx  output  1  UART serial line, idle high.

Function
REQ-012 Accept send only when busy=0; on the accepting edge latch msg_type/row/col, set busy=1, drive tx=0 (start bit of byte 0).
REQ-013 send while busy=1 SHALL be ignored; latched fields SHALL NOT change.
REQ-014 Packet = 3 bytes in order: header 0xA5; payload {msg_type,row,col} (msg_type in bits 7:6, row in 5:3, col in 2:0); checksum = 0xA5 XOR payload.
REQ-015 Each byte framed 8N1: start bit 0, 8 data bits LSB first, stop bit 1; every bit held exactly CLKS_PER_BIT cycles.
REQ-016 Bytes sent back-to-back; start bit of byte n+1 begins on the cycle immediately after the stop bit of byte n ends; no idle gap.
REQ-017 FSM states: IDLE, START, DATA, STOP; 2-bit byte index 0..2 and 3-bit bit index 0..7; STOP with byte index 2 returns to IDLE; STOP with index <2 goes to START with index+1.
REQ-018 Baud counter counts 0..CLKS_PER_BIT-1 and SHALL wrap to 0 on each bit boundary; reloads to 0 on packet acceptance.
REQ-019 busy SHALL remain high for exactly 30*CLKS_PER_BIT cycles after the accepting edge.
REQ-020 On the edge ending the final stop bit: busy<=0, done<=1, tx stays 1; done SHALL fall on the following edge.
REQ-021 send asserted in the cycle done=1 SHALL be accepted (busy already 0); new start bit follows with no extra idle.
REQ-022 tx SHALL be 1 at all times in IDLE; all outputs registered, no combinational path from inputs to tx.
REQ-023 send held high continuously SHALL produce consecutive packets, each re-latching inputs at its acceptance edge.

Reset
REQ-024 While rst=1: tx=1, busy=0, done=0, FSM=IDLE, all counters and indices 0, latched fields 0.
REQ-025 rst asserted mid-packet SHALL abort; tx=1 from the following cycle; no done pulse; send sampled with rst=1 ignored.

Verification (CLK_FREQ=40, BAUD=10, CLKS_PER_BIT=4)
REQ-026 Reset: rst high 3 cycles -> tx=1, busy=0, done=0 throughout and on release.
REQ-027 send pulse, msg_type=01, row=3, col=5 -> tx bytes decode A5, 5D, F8; busy high exactly 120 cycles; single done pulse on cycle 121.
REQ-028 send re-pulsed at cycle 50 of a packet with different fields -> ignored; decoded bytes unchanged; only one done.
REQ-029 send held high 250 cycles with msg_type=11, row=7, col=7 -> two back-to-back packets A5, FF, 5A with no idle bit between them; second accepted in done cycle.
REQ-030 rst at cycle 40 of a packet -> tx=1 next cycle, busy=0, no done; later send with row=0, col=0, msg_type=00 -> A5, 00, A5.
REQ-031 Bit timing: every tx transition during a packet occurs on a multiple of 4 cycles after the acceptance edge.
